// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: RV32I load/store funct3 codes, MMIO map and
// the access-controller state encoding.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ADDR_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_ISSUE   = 3'd3,
    RESP       = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check: access size (funct3[1:0]) against the low address bits.
module mem_align_check (
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    if (size[1])
      misaligned = (addr_lo != 2'b00);
    else if (size[0])
      misaligned = addr_lo[0];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory initiator for the multi-cycle RV32I core: serialises fetches and load/stores
// onto the single memory port with registered strobes and a 1-cycle read latency.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_instr,
  input  logic        ls_req,
  input  logic        ls_write,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic        ls_misaligned,
  output logic [31:0] ls_rdata,
  output logic        ready,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  mem_state_t  state;
  logic        is_fetch;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic        acc_mis;

  // Load/store wins arbitration; a fetch is always a word access.
  always_comb begin
    acc_f3   = ls_req ? ls_funct3 : F3_LW;
    acc_addr = ls_req ? ls_addr   : fetch_pc;
  end

  mem_align_check u_align (
    .size       (acc_f3[1:0]),
    .addr_lo    (acc_addr[1:0]),
    .misaligned (acc_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      is_fetch          <= 1'b0;
      ready             <= 1'b1;
      fetch_valid       <= 1'b0;
      fetch_fault       <= 1'b0;
      fetch_instr       <= '0;
      ls_done           <= 1'b0;
      ls_misaligned     <= 1'b0;
      ls_rdata          <= '0;
      mem_write_mem     <= 1'b0;
      mem_funct3        <= F3_LW;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_read_address  <= RESET_PC;
    end else begin
      fetch_valid   <= 1'b0;
      fetch_fault   <= 1'b0;
      ls_done       <= 1'b0;
      ls_misaligned <= 1'b0;
      mem_write_mem <= 1'b0;
      case (state)
        IDLE: begin
          if (ls_req || fetch_req) begin
            is_fetch <= !ls_req;
            ready    <= 1'b0;
            if (acc_mis) begin
              // Reject without touching the memory port.
              state <= RESP;
              if (ls_req) begin
                ls_done       <= 1'b1;
                ls_misaligned <= 1'b1;
                ls_rdata      <= '0;
              end else begin
                fetch_valid <= 1'b1;
                fetch_fault <= 1'b1;
                fetch_instr <= '0;
              end
            end else if (ls_req && ls_write) begin
              state             <= WR_ISSUE;
              mem_write_mem     <= 1'b1;
              mem_write_address <= ls_addr;
              mem_write_data    <= ls_wdata;
              mem_funct3        <= ls_funct3;
            end else begin
              state            <= RD_ISSUE;
              mem_read_address <= acc_addr;
              mem_funct3       <= acc_f3;
            end
          end
        end
        RD_ISSUE: state <= RD_CAPTURE;
        RD_CAPTURE: begin
          state <= IDLE;
          ready <= 1'b1;
          if (is_fetch) begin
            fetch_instr <= mem_read_data;
            fetch_valid <= 1'b1;
          end else begin
            ls_rdata <= mem_read_data;
            ls_done  <= 1'b1;
          end
        end
        WR_ISSUE: begin
          state   <= IDLE;
          ready   <= 1'b1;
          ls_done <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
